// File: rtl/os_psum_drain_pkg.sv
// Shared definitions for the output-stationary psum drain block:
// FSM encoding, default drain latency, a lane-slice macro and a pointer-width helper.
`ifndef OS_PSUM_DRAIN_LANE
`define OS_PSUM_DRAIN_LANE(bus, c, bw) bus[(c)*(bw) +: (bw)]
`endif

package os_psum_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_OUT  = 2'd3
  } drain_state_t;

  // Cycles from the first flush-high cycle to the first valid beat on array_s.
  localparam int DRAIN_LAT_DEFAULT = 2;

  // Width of an index into 0..n-1, never narrower than one bit.
  function automatic int ptr_w(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// Synchronous row FIFO holding one drained burst (data + row tag).
// Push and pop in the same cycle are both honoured. When empty, rdata keeps
// the last popped entry so downstream sees a stable bus.
module psum_row_fifo
  import os_psum_drain_pkg::*;
#(
  parameter int width = 34,
  parameter int depth = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wr,
  input  logic [width-1:0]               wdata,
  input  logic                           rd,
  output logic [width-1:0]               rdata,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(depth+1)-1:0]     count
);

  localparam int AW = ptr_w(depth);
  localparam int CW = $clog2(depth + 1);

  logic [width-1:0] mem_r [depth];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [width-1:0] hold_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Pointers wrap modulo depth, which need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(depth - 1)) begin
      return AW'(0);
    end else begin
      return p + AW'(1);
    end
  endfunction

  assign full    = (count_r == CW'(depth));
  assign empty   = (count_r == CW'(0));
  assign count   = count_r;
  assign wr_ok_s = wr & ~full;
  assign rd_ok_s = rd & ~empty;

  // Head of queue, or the last popped entry while empty.
  always_comb begin
    rdata = hold_r;
    if (empty) begin
      rdata = hold_r;
    end else begin
      rdata = mem_r[rd_ptr_r];
    end
  end

  // Storage, pointers, occupancy and the hold register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
      hold_r   <= '0;
    end else begin
      if (wr_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
      end
      if (rd_ok_s) begin
        hold_r   <= mem_r[rd_ptr_r];
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/os_psum_drain.sv
// South-edge receiver for the systolic array in output-stationary mode.
// Raises the array-wide flush, captures one row per cycle from the bottom
// edge (bottom row first), and replays the rows over valid/ready.
module os_psum_drain
  import os_psum_drain_pkg::*;
#(
  parameter int col       = 8,
  parameter int row       = 8,
  parameter int psum_bw   = 16,
  parameter int DRAIN_LAT = DRAIN_LAT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       os_mode,
  output logic                       flush,
  input  logic [col*psum_bw-1:0]     array_s,
  output logic [col*psum_bw-1:0]     out_data,
  output logic [ptr_w(row)-1:0]      out_row,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int DW = col * psum_bw;
  localparam int RW = ptr_w(row);
  localparam int WW = ptr_w(DRAIN_LAT);
  localparam int CW = $clog2(row + 1);

  drain_state_t   state_r, state_nx;
  logic           flush_r, flush_nx;
  logic           busy_r, busy_nx;
  logic           err_r, err_nx;
  logic [WW-1:0]  wait_r, wait_nx;
  logic [RW-1:0]  tag_r, tag_nx;

  logic           start_ok_s;
  logic           push_s;
  logic           pop_s;
  logic           last_pop_s;
  logic           fifo_full_s;
  logic           fifo_empty_s;
  logic [CW-1:0]  fifo_count_s;
  logic [DW+RW-1:0] rdata_s;

  assign start_ok_s = start & os_mode & (state_r == ST_IDLE);
  // The array cannot stall: every CAPT cycle is a push.
  assign push_s     = (state_r == ST_CAPT) & ~fifo_full_s;
  assign pop_s      = ~fifo_empty_s & out_ready;
  assign last_pop_s = (state_r == ST_OUT) & pop_s & (fifo_count_s == CW'(1));

  assign flush     = flush_r;
  assign busy      = busy_r;
  assign err       = err_r;
  assign out_valid = ~fifo_empty_s;
  assign out_data  = rdata_s[DW-1:0];
  assign out_row   = rdata_s[DW +: RW];

  psum_row_fifo #(
    .width (DW + RW),
    .depth (row)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (push_s),
    .wdata ({tag_r, array_s}),
    .rd    (pop_s),
    .rdata (rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Next-state and control decode; done is combinational so it marks the pop cycle itself.
  always_comb begin
    state_nx = state_r;
    flush_nx = flush_r;
    busy_nx  = busy_r;
    wait_nx  = wait_r;
    tag_nx   = tag_r;
    done     = 1'b0;
    // Any start that is not accepted is reported, including one on the done cycle.
    err_nx   = start & ~start_ok_s;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          state_nx = ST_WAIT;
          flush_nx = 1'b1;
          busy_nx  = 1'b1;
          wait_nx  = WW'(DRAIN_LAT - 1);
          tag_nx   = RW'(row - 1);
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_r == WW'(0)) begin
          state_nx = ST_CAPT;
        end else begin
          wait_nx = wait_r - WW'(1);
        end
      end
      ST_CAPT: begin
        // Row tags count down: bottom row arrives first, row 0 last.
        if (tag_r == RW'(0)) begin
          state_nx = ST_OUT;
          flush_nx = 1'b0;
        end else begin
          tag_nx = tag_r - RW'(1);
        end
      end
      ST_OUT: begin
        if (last_pop_s) begin
          state_nx = ST_IDLE;
          busy_nx  = 1'b0;
          done     = 1'b1;
        end else begin
          state_nx = ST_OUT;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        flush_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  // State and control registers; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      flush_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      wait_r  <= WW'(0);
      tag_r   <= RW'(0);
    end else begin
      state_r <= state_nx;
      flush_r <= flush_nx;
      busy_r  <= busy_nx;
      err_r   <= err_nx;
      wait_r  <= wait_nx;
      tag_r   <= tag_nx;
    end
  end

endmodule

// File: tb/tb_os_psum_drain.sv
// Scoreboard bench for os_psum_drain (row=4, col=2, psum_bw=16).
// A tile model answers flush with the preloaded rows; every presented row is
// queued as an expected beat and compared when the consumer pops it.
module tb_os_psum_drain;

  localparam int COL = 2;
  localparam int ROW = 4;
  localparam int BW  = 16;
  localparam int DW  = COL * BW;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          os_mode = 1'b1;
  logic          flush;
  logic [DW-1:0] array_s = '0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_row;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  logic [DW+1:0] exp_q [$];

  os_psum_drain #(
    .col(COL), .row(ROW), .psum_bw(BW), .DRAIN_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .os_mode(os_mode), .flush(flush),
    .array_s(array_s), .out_data(out_data), .out_row(out_row),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Tile model, scoreboard producer and consumer-side checker, all at negedge.
  int            fh = 0;
  logic          prev_flush = 1'b0;
  int            pops = 0;
  int            burst = 0;
  logic          stalled_prev = 1'b0;
  logic [DW+1:0] held = '0;
  always @(negedge clk) begin
    int idx;
    int r;
    logic [DW+1:0] e;
    logic [DW-1:0] w;
    logic exp_done;
    if (!reset) begin
      exp_q.delete();
      fh = 0; prev_flush = 1'b0; pops = 0; stalled_prev = 1'b0;
      array_s = 32'hDEAD_BEEF;
    end else begin
      idx = -1;
      if (flush) begin
        if (!prev_flush) burst++;
        idx = fh;
        fh++;
      end else begin
        if (prev_flush) check_val("flush_len", 64'(fh), 64'(ROW + LAT));
        fh = 0;
      end
      prev_flush = flush;
      if (idx >= LAT && idx < LAT + ROW) begin
        r = ROW - 1 - (idx - LAT);
        for (int c = 0; c < COL; c++) w[c*BW +: BW] = BW'(r * 10 + c + (burst - 1) * 100);
        array_s = w;
        exp_q.push_back({2'(r), w});
      end else begin
        array_s = 32'hDEAD_BEEF;
      end
      exp_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("pop_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("beat_data", 64'(out_data), 64'(e[DW-1:0]));
          check_val("beat_row", 64'(out_row), 64'(e[DW+1:DW]));
        end
        exp_done = (pops == ROW - 1);
        pops = exp_done ? 0 : pops + 1;
      end
      check_val("done", 64'(done), 64'(exp_done));
      if (stalled_prev && out_valid) check_val("hold_stable", 64'({out_row, out_data}), 64'(held));
      stalled_prev = out_valid && !out_ready;
      held = {out_row, out_data};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic mode);
    start = 1'b1;
    os_mode = mode;
    tick();
    start = 1'b0;
    os_mode = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check_val(tag, 64'(busy), 64'd0);
    tick();
    check_val({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int first_v;
    int done_k;
    int cmax;
    int n;
    // Reset state
    tick(); tick();
    check_val("rst_flush", 64'(flush), 64'd0);
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_data", 64'(out_data), 64'd0);
    check_val("rst_row", 64'(out_row), 64'd0);
    reset = 1'b1;
    tick();

    // 1: basic drain
    out_ready = 1'b1;
    pulse_start(1'b1);
    check_val("t1_busy", 64'(busy), 64'd1);
    check_val("t1_flush", 64'(flush), 64'd1);
    wait_idle("t1_idle");

    // 2: backpressure through the whole capture
    out_ready = 1'b0;
    pulse_start(1'b1);
    n = 0;
    while (flush && n < 20) begin tick(); n++; end
    check_val("t2_flush_drop", 64'(flush), 64'd0);
    tick(); tick();
    check_val("t2_valid", 64'(out_valid), 64'd1);
    check_val("t2_count", 64'(dut.u_fifo.count_r), 64'd4);
    check_val("t2_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_idle("t2_idle");

    // 3: streaming overlap, timing relative to first flush cycle F
    out_ready = 1'b1;
    pulse_start(1'b1);
    first_v = -1; done_k = -1; cmax = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid && first_v < 0) first_v = k;
      if (done) done_k = k;
      if (int'(dut.u_fifo.count_r) > cmax) cmax = int'(dut.u_fifo.count_r);
      tick();
    end
    check_val("t3_first_valid", 64'(first_v), 64'd3);
    check_val("t3_done_cycle", 64'(done_k), 64'd6);
    check_val("t3_count_max", 64'(cmax), 64'd1);
    wait_idle("t3_idle");

    // 4a: start with os_mode=0
    pulse_start(1'b0);
    check_val("t4_err_mode", 64'(err), 64'd1);
    check_val("t4_flush_mode", 64'(flush), 64'd0);
    check_val("t4_busy_mode", 64'(busy), 64'd0);
    tick();
    check_val("t4_err_clear", 64'(err), 64'd0);
    // 4b: start during capture
    pulse_start(1'b1);
    tick(); tick(); tick();
    pulse_start(1'b1);
    check_val("t4_err_capt", 64'(err), 64'd1);
    check_val("t4_busy_capt", 64'(busy), 64'd1);
    wait_idle("t4_idle");

    // 5: reset in the second capture cycle
    pulse_start(1'b1);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check_val("t5_flush", 64'(flush), 64'd0);
    check_val("t5_valid", 64'(out_valid), 64'd0);
    check_val("t5_busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();
    pulse_start(1'b1);
    wait_idle("t5_idle");

    // 6: back-to-back around done
    pulse_start(1'b1);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    check_val("t6_done_seen", 64'(done), 64'd1);
    start = 1'b1;
    tick();
    check_val("t6_err_on_done", 64'(err), 64'd1);
    check_val("t6_busy_low", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    check_val("t6_err_accept", 64'(err), 64'd0);
    check_val("t6_busy_accept", 64'(busy), 64'd1);
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
